// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers for the MIPS datapath. Executes mult/multu/div/divu
//               one bit per cycle and serves mfhi/mflo/mthi/mtlo. The
//               start/busy/done handshake lets the controller stall the pipe.
// Ports       : clk     - clock, all state changes on the rising edge
//               resetN  - asynchronous active-low reset
//               start   - request, sampled only while idle
//               funct   - R-type funct field selecting the operation
//               srcA    - rs operand (multiplicand / dividend / move data)
//               srcB    - rt operand (multiplier / divisor)
//               busy    - operation in flight, new requests ignored
//               done    - one-cycle pulse when HI/LO take a mult/div result
//               illegal - one-cycle pulse after a start with unknown funct
//               hi, lo  - architectural HI/LO registers
//               result  - hi for mfhi, lo for mflo, else zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] c_MFHI  = 6'd16;
  localparam logic [5:0] c_MTHI  = 6'd17;
  localparam logic [5:0] c_MFLO  = 6'd18;
  localparam logic [5:0] c_MTLO  = 6'd19;
  localparam logic [5:0] c_MULT  = 6'd24;
  localparam logic [5:0] c_MULTU = 6'd25;
  localparam logic [5:0] c_DIV   = 6'd26;
  localparam logic [5:0] c_DIVU  = 6'd27;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_opa;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0]   r_acc;     // {upper, lower}: product, or {remainder, quotient}
  logic                 r_neg_lo;  // negate product / quotient in FIX
  logic                 r_neg_hi;  // negate remainder in FIX
  logic                 r_is_div;
  logic                 r_divz;

  // Operand magnitudes; only the signed opcodes strip the sign
  logic             w_is_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_maga;
  logic [WIDTH-1:0] w_magb;

  assign w_is_signed = (funct == c_MULT) || (funct == c_DIV);
  assign w_sa        = w_is_signed & srcA[WIDTH-1];
  assign w_sb        = w_is_signed & srcB[WIDTH-1];
  assign w_maga      = w_sa ? (~srcA + WIDTH'(1)) : srcA;
  assign w_magb      = w_sb ? (~srcB + WIDTH'(1)) : srcB;

  // Shift-add step: the multiplier sits in the low half and is consumed LSB
  // first while the partial product grows in from the top.
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_acc[0] ? r_opa : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring division step: the trial subtract uses WIDTH+1 bits so the
  // partial remainder shifted left cannot overflow.
  logic [WIDTH:0]       w_div_part;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;

  assign w_div_part = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_part - {1'b0, r_opa};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_div_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX. Most-negative / -1 needs no special case:
  // the quotient magnitude is already the most-negative pattern and its sign
  // bit cancels. For divide-by-zero the remainder magnitude is |srcA| and the
  // dividend-sign correction restores srcA exactly; only LO must be forced.
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign w_prod   = r_neg_lo ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
  assign w_quo    = r_neg_lo ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                             : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? (r_divz ? {WIDTH{1'b1}} : w_quo) : w_prod[WIDTH-1:0];

  always_comb begin
    result = '0;
    if (funct == c_MFHI) begin
      result = hi;
    end else if (funct == c_MFLO) begin
      result = lo;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_acc    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_is_div <= 1'b0;
      r_divz   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (funct)
              c_MULT, c_MULTU: begin
                r_opa    <= w_maga;
                r_acc    <= {{WIDTH{1'b0}}, w_magb};
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= 1'b0;
                r_is_div <= 1'b0;
                r_divz   <= 1'b0;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= S_MUL;
              end
              c_DIV, c_DIVU: begin
                r_opa    <= w_magb;
                r_acc    <= {{WIDTH{1'b0}}, w_maga};
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= w_sa;
                r_is_div <= 1'b1;
                r_divz   <= (srcB == '0);
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= S_DIV;
              end
              c_MTHI:          hi <= srcA;
              c_MTLO:          lo <= srcA;
              c_MFHI, c_MFLO: ;
              default:         illegal <= 1'b1;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_CNT_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_CNT_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          hi      <= w_fix_hi;
          lo      <= w_fix_lo;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Directed self-checking bench for alu_muldiv (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  logic         clk    = 1'b0;
  logic         resetN = 1'b0;
  logic         start  = 1'b0;
  logic [5:0]   funct  = 6'd0;
  logic [W-1:0] srcA   = '0;
  logic [W-1:0] srcB   = '0;
  logic         busy;
  logic         done;
  logic         illegal;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .start   (start),
    .funct   (funct),
    .srcA    (srcA),
    .srcB    (srcB),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the following posedge is the accept edge and the
  // task returns at the negedge right after it.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    funct = f;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high, bounded so a stuck DUT still terminates.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Full operation: returns busy cycle count, done/hi/lo in the done cycle and
  // done one cycle later.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n, output logic d1, output logic [W-1:0] h,
                        output logic [W-1:0] l, output logic d2);
    @(negedge clk);
    issue(f, a, b);
    wait_busy(n);
    d1 = done;
    h  = hi;
    l  = lo;
    @(negedge clk);
    d2 = done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    funct = F_MFHI;
    #1;
    checks++; if ({busy, done, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, illegal}); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_multu_max();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, d1, h, l, d2);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", n); end
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", d1); end
    checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", d2); end
    checks++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", h, l); end
  endtask

  task automatic test_mult_signed();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", h, l); end
    run_op(F_MULT, 32'h80000000, 32'h80000000, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_minxmin: got %h_%h want 40000000_00000000", h, l); end
    run_op(F_MULTU, 32'h80000000, 32'd2, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h00000001_00000000) begin errors++; $display("FAIL multu_carry: got %h_%h want 00000001_00000000", h, l); end
  endtask

  task automatic test_div_signed();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2, n, d1, h, l, d2);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_busy_cycles: got %0d want 33", n); end
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg7by2: got %h_%h want ffffffff_fffffffd", h, l); end
    run_op(F_DIV, 32'd7, 32'hFFFFFFFE, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_7byneg2: got %h_%h want 00000001_fffffffd", h, l); end
    run_op(F_DIVU, 32'hFFFFFFFF, 32'd16, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL divu_big: got %h_%h want 0000000f_0fffffff", h, l); end
  endtask

  task automatic test_div_zero();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_DIVU, 32'd7, 32'd0, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h00000007_FFFFFFFF) begin errors++; $display("FAIL divu_by_zero: got %h_%h want 00000007_ffffffff", h, l); end
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL divu_by_zero_done: got %b want 1", d1); end
    run_op(F_DIV, 32'hFFFFFFF8, 32'd0, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'hFFFFFFF8_FFFFFFFF) begin errors++; $display("FAIL div_by_zero: got %h_%h want fffffff8_ffffffff", h, l); end
  endtask

  task automatic test_div_overflow();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, n, d1, h, l, d2);
    checks++; if ({h, l} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", h, l); end
  endtask

  // Preceding state: hi = 0, lo = 0x80000000.
  task automatic test_mthi();
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; srcA = 32'h1234;
    @(negedge clk);
    start = 1'b0; funct = F_MFHI;
    #1;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
    checks++; if (result !== 32'h1234) begin errors++; $display("FAIL mfhi_result: got %h want 00001234", result); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mthi_no_busy: got %b want 00", {busy, done}); end
    funct = F_MFLO;
    #1;
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL mflo_result: got %h want 80000000", result); end
    funct = 6'd20;
    #1;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL result_other: got %h want 00000000", result); end
  endtask

  task automatic test_mtlo_busy();
    int n;
    @(negedge clk);
    issue(F_MULTU, 32'd5, 32'd6);
    @(negedge clk);
    start = 1'b1; funct = F_MTLO; srcA = 32'h55;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL mtlo_busy_ignored: got %h want 80000000", lo); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mtlo_busy_illegal: got %b want 0", illegal); end
    wait_busy(n);
    checks++; if (n !== 31) begin errors++; $display("FAIL mtlo_busy_cycles: got %0d want 31", n); end
    checks++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd30}) begin errors++; $display("FAIL mtlo_busy_result: got done=%b %h_%h want 1 00000000_0000001e", done, hi, lo); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    issue(6'd32, 32'hDEAD, 32'hBEEF);
    checks++; if ({illegal, busy} !== 2'b10) begin errors++; $display("FAIL illegal_pulse: got %b want 10", {illegal, busy}); end
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %b want 0", illegal); end
    checks++; if ({hi, lo} !== 64'h00000000_0000001E) begin errors++; $display("FAIL illegal_hilo: got %h_%h want 00000000_0000001e", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_busy(n);
    checks++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd1}) begin errors++; $display("FAIL b2b_first: got done=%b %h_%h want 1 00000000_00000001", done, hi, lo); end
    issue(F_DIVU, 32'd100, 32'd7);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
    wait_busy(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 33", n); end
    checks++; if ({done, hi, lo} !== {1'b1, 32'd2, 32'd14}) begin errors++; $display("FAIL b2b_second: got done=%b %h_%h want 1 00000002_0000000e", done, hi, lo); end
  endtask

  // Preceding state: hi = 2, lo = 14.
  task automatic test_reset_abort();
    @(negedge clk);
    issue(F_MULTU, 32'hFFFF, 32'hFFFF);
    repeat (9) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b want 00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h_%h want 00000000_00000000", hi, lo); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, hi, lo} !== 66'h0) begin errors++; $display("FAIL abort_idle: got busy=%b done=%b %h_%h want 0 0 0_0", busy, done, hi, lo); end
  endtask

  task automatic test_after_reset();
    int n; logic d1, d2; logic [W-1:0] h, l;
    run_op(F_MULTU, 32'd2, 32'd3, n, d1, h, l, d2);
    checks++; if (n !== 33) begin errors++; $display("FAIL post_reset_cycles: got %0d want 33", n); end
    checks++; if ({d1, h, l} !== {1'b1, 32'd0, 32'd6}) begin errors++; $display("FAIL post_reset_multu: got done=%b %h_%h want 1 00000000_00000006", d1, h, l); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_mthi();
    test_mtlo_busy();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath, sitting beside the combinational ALU and steered by the same R-type `funct` field. It executes mult/multu/div/divu iteratively (one bit per cycle), holds results in architectural HI/LO, and serves mfhi/mflo/mthi/mtlo. A start/busy/done handshake lets the controller stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand, HI and LO width (≥ 4).
- `clk` in 1: single clock; all state changes on rising edge.
- `resetN` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `funct` in 6: 16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu.
- `srcA` in WIDTH: rs operand (multiplicand / dividend / mthi-mtlo data).
- `srcB` in WIDTH: rt operand (multiplier / divisor).
- `busy` out 1: operation in flight; new requests ignored.
- `done` out 1: one-cycle pulse when HI/LO receive a mult/div result.
- `illegal` out 1: one-cycle pulse after `start` in IDLE with a funct outside the list.
- `hi`, `lo` out WIDTH: architectural registers.
- `result` out WIDTH: combinational; `hi` when funct=16, `lo` when funct=18, else 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + funct 24/25: latch |srcA|, |srcB| (magnitudes only for 24) and the result sign → MUL, counter=0.
- IDLE + start + funct 26/27: latch magnitudes, quotient sign = sA^sB, remainder sign = sA (signed only) → DIV.
- IDLE + start + funct 17/19: write `hi`/`lo` = srcA at that edge; stay IDLE; no busy, no done.
- IDLE + start + funct 16/18: no state change (read is combinational).
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH accumulator; after WIDTH cycles → FIX.
- DIV: restoring division, one quotient bit per cycle; after WIDTH cycles → FIX.
- FIX: apply two's-complement sign correction; write HI (upper product / remainder) and LO (lower product / quotient); → IDLE; `done` high the following cycle.
- Signed product: full 2·WIDTH-bit two's-complement result.
- Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): LO = all ones, HI = srcA unchanged; FIX forces these values.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- `start` in MUL/DIV/FIX (any funct, including mthi/mtlo): ignored, no queuing, no `illegal`.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `illegal`=0, internal counter/accumulators 0.
- Accept edge T0. `busy`=1 from after T0 until the FIX→IDLE edge T(WIDTH+1).
- HI/LO are updated at T(WIDTH+1). `done`=1 for exactly the cycle after T(WIDTH+1), with `busy`=0 in that same cycle.
- Latency: WIDTH+1 cycles accept-to-result (33 at WIDTH=32).
- Back-to-back: `start` may be issued in the cycle where `done`=1; it is accepted, since the state is IDLE.
- mthi/mtlo: new value is visible on `hi`/`lo`/`result` the cycle after the accept edge.
- `resetN` low at any time: immediately abort the operation and clear all state. Partial results are never written.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` high 33 cycles; `done` single pulse at cycle 33 after accept.
- mult −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7 ÷ 0 → LO=0xFFFFFFFF, HI=0x00000007.
- div 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1234 in IDLE → `hi`=0x1234 next cycle, `result`=0x1234 with funct 16.
- mtlo 0x55 issued while busy → ignored, `lo` gets the mult result.
- funct 32 with start → `illegal` one pulse, HI/LO unchanged.
- `resetN` low 10 cycles into a mult → `busy`/`done`=0 and `hi`/`lo`=0 immediately.
- After reset release, a new multu 2×3 → LO=6, HI=0.
